// File: rtl/chacha_stream_sched.sv
// rtl/chacha_stream_sched.sv - round-robin frame scheduler and config loader for the serial ChaCha20 core
//
// Arbitrates two bit-serial plaintext requesters onto one encrypter core, one
// whole frame at a time. Loads key/nonce/counter with a one-cycle lock pulse and
// relocks every BLOCK_BITS bits with the next counter value. Ciphertext leaves
// the core CORE_LAT cycles after its plaintext bit and is re-tagged here.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   cfg_valid/cfg_ready              key/nonce/counter handshake (ready only in IDLE)
//   cfg_key, cfg_nonce, cfg_ctr      configuration values
//   req_valid/req_bit/req_last       per-requester plaintext bit stream
//   req_ready                        per-requester consume strobe
//   core_key/core_nonce/core_init_value, core_lock, core_pt1, core_pt2  core drive
//   core_out                         core ciphertext bit
//   out_valid/out_bit/out_src/out_last  realigned ciphertext stream
//   ctr_exhausted                    sticky block-counter wrap flag
module chacha_stream_sched #(
  parameter int BLOCK_BITS = 8,
  parameter int CORE_LAT   = 1,
  parameter int WARM_CYC   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [7:0] cfg_key,
  input  logic [1:0] cfg_nonce,
  input  logic [1:0] cfg_ctr,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_bit,
  input  logic [1:0] req_last,
  output logic [1:0] req_ready,
  output logic [7:0] core_key,
  output logic [1:0] core_nonce,
  output logic [1:0] core_init_value,
  output logic       core_lock,
  output logic       core_pt1,
  output logic       core_pt2,
  input  logic       core_out,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_src,
  output logic       out_last,
  output logic       ctr_exhausted
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WARM   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;

  localparam int BW = $clog2(BLOCK_BITS + 1);
  localparam int WW = $clog2(WARM_CYC + 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    key_q, key_d;
  logic [1:0]    nonce_q, nonce_d;
  logic [1:0]    ctr_q, ctr_d;
  logic          held_q, held_d;
  logic          exh_q, exh_d;
  logic          gnt_q, gnt_d;
  logic          gnt_act_q, gnt_act_d;
  logic          rr_q, rr_d;
  logic [BW-1:0] bits_q, bits_d;
  logic [WW-1:0] warm_q, warm_d;
  logic          cfg_ready_q;
  logic [2:0]    pipe_q [CORE_LAT];
  logic          take_c, last_c;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    nonce_d   = nonce_q;
    ctr_d     = ctr_q;
    held_d    = held_q;
    exh_d     = exh_q;
    gnt_d     = gnt_q;
    gnt_act_d = gnt_act_q;
    rr_d      = rr_q;
    bits_d    = bits_q;
    warm_d    = warm_q;
    req_ready = 2'b00;
    take_c    = 1'b0;
    last_c    = 1'b0;
    core_pt1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          // Config wins over a pending grant; its lock only loads the core.
          key_d     = cfg_key;
          nonce_d   = cfg_nonce;
          ctr_d     = cfg_ctr;
          held_d    = 1'b1;
          exh_d     = 1'b0;
          gnt_act_d = 1'b0;
          state_d   = S_LOAD;
        end else if (held_q && !exh_q && (req_valid != 2'b00)) begin
          gnt_d     = (req_valid == 2'b11) ? rr_q : req_valid[1];
          gnt_act_d = 1'b1;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        warm_d  = '0;
        state_d = S_WARM;
      end
      S_WARM: begin
        if (warm_q == WW'(WARM_CYC - 1)) begin
          state_d = gnt_act_q ? S_STREAM : S_IDLE;
        end else begin
          warm_d = warm_q + WW'(1);
        end
      end
      S_STREAM: begin
        req_ready[gnt_q] = req_valid[gnt_q];
        if (req_valid[gnt_q]) begin
          take_c   = 1'b1;
          last_c   = req_last[gnt_q];
          core_pt1 = req_bit[gnt_q];
          if (req_last[gnt_q]) begin
            // The last bit wins over a block boundary on the same bit.
            ctr_d     = ctr_q + 2'd1;
            exh_d     = exh_q | (ctr_q == 2'b11);
            bits_d    = '0;
            gnt_act_d = 1'b0;
            rr_d      = ~gnt_q;
            state_d   = S_IDLE;
          end else if (bits_q == BW'(BLOCK_BITS - 1)) begin
            bits_d  = '0;
            state_d = S_NEXT;
          end else begin
            bits_d = bits_q + BW'(1);
          end
        end
      end
      S_NEXT: begin
        // A wrap here only flags exhaustion; the frame still runs to its end.
        ctr_d   = ctr_q + 2'd1;
        exh_d   = exh_q | (ctr_q == 2'b11);
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      held_q      <= 1'b0;
      exh_q       <= 1'b0;
      gnt_q       <= 1'b0;
      gnt_act_q   <= 1'b0;
      rr_q        <= 1'b0;
      bits_q      <= '0;
      warm_q      <= '0;
      cfg_ready_q <= 1'b0;
      for (int i = 0; i < CORE_LAT; i++) pipe_q[i] <= 3'b000;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      held_q      <= held_d;
      exh_q       <= exh_d;
      gnt_q       <= gnt_d;
      gnt_act_q   <= gnt_act_d;
      rr_q        <= rr_d;
      bits_q      <= bits_d;
      warm_q      <= warm_d;
      // Registered so the flag reads 0 while reset is held.
      cfg_ready_q <= (state_d == S_IDLE);
      pipe_q[0]   <= {take_c, gnt_q, last_c};
      for (int i = 1; i < CORE_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign cfg_ready       = cfg_ready_q;
  assign core_key        = key_q;
  assign core_nonce      = nonce_q;
  assign core_init_value = ctr_q;
  assign core_lock       = (state_q == S_LOAD);
  assign core_pt2        = 1'b0;
  assign ctr_exhausted   = exh_q;
  assign out_valid       = pipe_q[CORE_LAT-1][2];
  assign out_src         = pipe_q[CORE_LAT-1][1];
  assign out_last        = pipe_q[CORE_LAT-1][0];
  assign out_bit         = out_valid & core_out;

endmodule
